// File: rtl/wb_commit_stage.sv
// ---------------------------------------------------------------------------
// wb_commit_stage
//
// Write-back pipeline register (W) of the pipeline. Captures memory-stage
// results one clock after they are presented, resolves a same-register
// dstE/dstM conflict in favour of the memory value, suppresses register
// writes of faulting instructions, freezes the pipeline tail once a
// non-AOK status reaches W, and counts retired instructions.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   M_stat/M_icode   memory-stage status and instruction code
//   M_dstE/M_dstM    memory-stage destinations (4'hF = none)
//   M_valE/m_valM    ALU result / memory read data
//   W_stall          hold the W register
//   W_bubble         load a bubble (INOP) into the W register
//   W_dstE..W_valM   register-file write pair (also used for forwarding)
//   W_icode          latched instruction code
//   Stat             processor status (status held in W)
//   halted           pipeline tail frozen
//   retired          retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module wb_commit_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       M_stat,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       M_dstE,
    input  logic [3:0]       M_dstM,
    input  logic [63:0]      M_valE,
    input  logic [63:0]      m_valM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [3:0]       W_dstE,
    output logic [63:0]      W_valE,
    output logic [3:0]       W_dstM,
    output logic [63:0]      W_valM,
    output logic [3:0]       W_icode,
    output logic [2:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [2:0]       stat_q,    stat_d;
    logic [3:0]       icode_q,   icode_d;
    logic [3:0]       dste_q,    dste_d;
    logic [3:0]       dstm_q,    dstm_d;
    logic [63:0]      vale_q,    vale_d;
    logic [63:0]      valm_q,    valm_d;
    logic             valid_q,   valid_d;
    logic             halted_q,  halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic m_fault;
    logic m_conflict;
    logic w_retire;

    // Next-state logic for the W register, tail FSM and retire counter.
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        icode_d   = icode_q;
        dste_d    = dste_q;
        dstm_d    = dstm_q;
        vale_d    = vale_q;
        valm_d    = valm_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        retired_d = retired_q;

        m_fault    = (M_stat == STAT_ADR) || (M_stat == STAT_INS);
        // popq %rsp: both writes target the same register, memory value wins
        m_conflict = (M_dstE == M_dstM) && (M_dstE != REG_NONE);
        // An instruction retires on the edge it leaves W; a stalled one stays
        w_retire   = valid_q && !W_stall &&
                     ((stat_q == STAT_AOK) || (stat_q == STAT_HLT));

        case (state_q)
            ST_RUN: begin
                if (valid_q && (stat_q != STAT_AOK)) begin
                    // Freeze the tail; kill destinations so no write repeats
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    dste_d   = REG_NONE;
                    dstm_d   = REG_NONE;
                end else if (W_stall) begin
                    valid_d = valid_q;
                end else if (W_bubble) begin
                    stat_d  = STAT_AOK;
                    icode_d = ICODE_NOP;
                    dste_d  = REG_NONE;
                    dstm_d  = REG_NONE;
                    vale_d  = 64'd0;
                    valm_d  = 64'd0;
                    valid_d = 1'b0;
                end else begin
                    stat_d  = M_stat;
                    icode_d = M_icode;
                    dste_d  = (m_fault || m_conflict) ? REG_NONE : M_dstE;
                    dstm_d  = m_fault ? REG_NONE : M_dstM;
                    vale_d  = M_valE;
                    valm_d  = m_valM;
                    valid_d = 1'b1;
                end

                if (w_retire) begin
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    retired_d = retired_q;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                // Unreachable encoding: fail safe by freezing the tail
                state_d  = ST_HALT;
                halted_d = 1'b1;
                dste_d   = REG_NONE;
                dstm_d   = REG_NONE;
            end
        endcase
    end

    // W register, FSM state and retire counter with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            stat_q    <= STAT_AOK;
            icode_q   <= ICODE_NOP;
            dste_q    <= REG_NONE;
            dstm_q    <= REG_NONE;
            vale_q    <= 64'd0;
            valm_q    <= 64'd0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            icode_q   <= icode_d;
            dste_q    <= dste_d;
            dstm_q    <= dstm_d;
            vale_q    <= vale_d;
            valm_q    <= valm_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign W_dstE  = dste_q;
    assign W_valE  = vale_q;
    assign W_dstM  = dstm_q;
    assign W_valM  = valm_q;
    assign W_icode = icode_q;
    assign Stat    = stat_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
